// File: rtl/pipeline_3stage.sv
// Three-stage in-order datapath: fetch from a 32-word instruction memory, execute with a single
// writeback-to-execute bypass, and write back into a 32-entry register file. Both memories are host-loadable.
module pipeline_3stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        imem_we,
  input  logic [4:0]  imem_waddr,
  input  logic [31:0] imem_wdata,
  input  logic        rf_we,
  input  logic [4:0]  rf_waddr,
  input  logic [31:0] rf_wdata,
  input  logic [4:0]  dbg_raddr,
  output logic [31:0] dbg_rdata,
  output logic [4:0]  pc,
  output logic [31:0] inst,
  output logic [31:0] result,
  output logic        wb_valid,
  output logic [4:0]  wb_rd
);

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_OR  = 2'b11
  } op_e;

  logic [31:0] imem_q    [32];
  logic [31:0] regfile_q [32];

  logic [4:0]  pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] result_q, result_d;
  logic        wb_valid_q, wb_valid_d;
  logic [4:0]  wb_rd_q, wb_rd_d;

  op_e         ex_op;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [31:0] op_a, op_b, alu_out;

  // Operands come from the instruction sitting in writeback when its destination matches.
  always_comb begin
    ex_op   = op_e'(inst_q[31:30]);
    ex_rs1  = inst_q[29:25];
    ex_rs2  = inst_q[24:20];
    ex_rd   = inst_q[19:15];
    op_a    = (wb_valid_q && (wb_rd_q == ex_rs1)) ? result_q : regfile_q[ex_rs1];
    op_b    = (wb_valid_q && (wb_rd_q == ex_rs2)) ? result_q : regfile_q[ex_rs2];
    alu_out = 32'h0;
    case (ex_op)
      OP_ADD:  alu_out = op_a + op_b;
      OP_SUB:  alu_out = op_a - op_b;
      OP_AND:  alu_out = op_a & op_b;
      OP_OR:   alu_out = op_a | op_b;
      default: alu_out = 32'h0;
    endcase
  end

  always_comb begin
    pc_d       = pc_q + 5'd1;
    inst_d     = imem_q[pc_q];
    if_valid_d = 1'b1;
    result_d   = result_q;
    wb_rd_d    = wb_rd_q;
    wb_valid_d = if_valid_q;
    if (if_valid_q) begin
      result_d = alu_out;
      wb_rd_d  = ex_rd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= 5'd0;
      inst_q     <= 32'h0;
      if_valid_q <= 1'b0;
      result_q   <= 32'h0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= 5'd0;
    end else begin
      pc_q       <= pc_d;
      inst_q     <= inst_d;
      if_valid_q <= if_valid_d;
      result_q   <= result_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
    end
  end

  // Storage is not reset; the writeback assignment comes last so it wins a same-address host write.
  always_ff @(posedge clk) begin
    if (imem_we) begin
      imem_q[imem_waddr] <= imem_wdata;
    end
    if (rf_we) begin
      regfile_q[rf_waddr] <= rf_wdata;
    end
    if (wb_valid_q) begin
      regfile_q[wb_rd_q] <= result_q;
    end
  end

  assign dbg_rdata = regfile_q[dbg_raddr];
  assign pc        = pc_q;
  assign inst      = inst_q;
  assign result    = result_q;
  assign wb_valid  = wb_valid_q;
  assign wb_rd     = wb_rd_q;

endmodule

// File: tb/tb_pipeline_3stage.sv
// Directed scenarios with constant expectations, then a randomized run checked against
// a program-order reference model that commits results two instructions behind fetch.
module tb_pipeline_3stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_we = 1'b0;
  logic [4:0]  imem_waddr = 5'd0;
  logic [31:0] imem_wdata = 32'h0;
  logic        rf_we = 1'b0;
  logic [4:0]  rf_waddr = 5'd0;
  logic [31:0] rf_wdata = 32'h0;
  logic [4:0]  dbg_raddr = 5'd0;
  logic [31:0] dbg_rdata;
  logic [4:0]  pc;
  logic [31:0] inst;
  logic [31:0] result;
  logic        wb_valid;
  logic [4:0]  wb_rd;

  int checks = 0;
  int errors = 0;

  logic [31:0] prog [32];
  logic [31:0] regs [32];

  pipeline_3stage dut (
    .clk(clk), .rst_n(rst_n),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata),
    .pc(pc), .inst(inst), .result(result), .wb_valid(wb_valid), .wb_rd(wb_rd)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL timeout: simulation did not complete within the time limit");
    $fatal(1, "[TB] timeout");
  end

  function automatic logic [31:0] mkInst(input logic [1:0] op, input logic [4:0] rs1,
                                         input logic [4:0] rs2, input logic [4:0] rd);
    return {op, rs1, rs2, rd, 15'h0};
  endfunction

  function automatic logic [31:0] refAlu(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a & b;
      default: return a | b;
    endcase
  endfunction

  function automatic logic [4:0] randReg();
    if ($urandom_range(0, 1) == 1) return 5'($urandom_range(0, 3));
    return 5'($urandom_range(0, 31));
  endfunction

  function automatic logic [31:0] randInst();
    return mkInst(2'($urandom_range(0, 3)), randReg(), randReg(), randReg());
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Loads prog/regs through the host ports while held in reset, then releases reset.
  task automatic loadDuringReset();
    rst_n = 1'b0;
    for (int i = 0; i < 32; i++) begin
      imem_we = 1'b1; imem_waddr = 5'(i); imem_wdata = prog[i];
      rf_we = 1'b1; rf_waddr = 5'(i); rf_wdata = regs[i];
      tick();
    end
    imem_we = 1'b0;
    rf_we = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++; if (pc !== 5'd0) begin errors++; $display("[TB] FAIL reset_pc: got %h expected %h", pc, 5'd0); end
    checks++; if (inst !== 32'h0) begin errors++; $display("[TB] FAIL reset_inst: got %h expected %h", inst, 32'h0); end
    checks++; if (result !== 32'h0) begin errors++; $display("[TB] FAIL reset_result: got %h expected %h", result, 32'h0); end
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_wb_valid: got %b expected 0", wb_valid); end
    checks++; if (wb_rd !== 5'd0) begin errors++; $display("[TB] FAIL reset_wb_rd: got %h expected %h", wb_rd, 5'd0); end
    tick();
  endtask

  task automatic test_alu_forwarding();
    for (int i = 0; i < 32; i++) begin prog[i] = 32'h0; regs[i] = 32'h0; end
    prog[0] = mkInst(2'd0, 5'd1, 5'd2, 5'd3);
    prog[1] = mkInst(2'd1, 5'd1, 5'd2, 5'd2);
    prog[2] = mkInst(2'd3, 5'd3, 5'd2, 5'd2);
    prog[3] = mkInst(2'd2, 5'd4, 5'd5, 5'd6);
    prog[4] = mkInst(2'd0, 5'd7, 5'd8, 5'd9);
    regs[1] = 32'd10; regs[2] = 32'd20; regs[4] = 32'h0000F0F0; regs[5] = 32'h0000FF00;
    regs[7] = 32'hFFFFFFFF; regs[8] = 32'd1; regs[9] = 32'h00005A5A;
    loadDuringReset();
    tick();
    checks++; if (pc !== 5'd1) begin errors++; $display("[TB] FAIL e1_pc: got %h expected %h", pc, 5'd1); end
    checks++; if (inst !== prog[0]) begin errors++; $display("[TB] FAIL e1_inst: got %h expected %h", inst, prog[0]); end
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("[TB] FAIL e1_wb_valid: got %b expected 0", wb_valid); end
    tick();
    checks++; if (result !== 32'd30) begin errors++; $display("[TB] FAIL add_result: got %h expected %h", result, 32'd30); end
    checks++; if (wb_valid !== 1'b1 || wb_rd !== 5'd3) begin errors++; $display("[TB] FAIL add_wb: got valid=%b rd=%0d expected valid=1 rd=3", wb_valid, wb_rd); end
    dbg_raddr = 5'd3;
    tick();
    checks++; if (dbg_rdata !== 32'd30) begin errors++; $display("[TB] FAIL add_r3: got %h expected %h", dbg_rdata, 32'd30); end
    checks++; if (result !== 32'hFFFFFFF6) begin errors++; $display("[TB] FAIL sub_result: got %h expected %h", result, 32'hFFFFFFF6); end
    dbg_raddr = 5'd2;
    tick();
    checks++; if (dbg_rdata !== 32'hFFFFFFF6) begin errors++; $display("[TB] FAIL sub_r2: got %h expected %h", dbg_rdata, 32'hFFFFFFF6); end
    checks++; if (result !== 32'hFFFFFFFE) begin errors++; $display("[TB] FAIL or_fwd_result: got %h expected %h", result, 32'hFFFFFFFE); end
    tick();
    checks++; if (dbg_rdata !== 32'hFFFFFFFE) begin errors++; $display("[TB] FAIL or_r2: got %h expected %h", dbg_rdata, 32'hFFFFFFFE); end
    checks++; if (result !== 32'h0000F000) begin errors++; $display("[TB] FAIL and_result: got %h expected %h", result, 32'h0000F000); end
    dbg_raddr = 5'd9;
    tick();
    checks++; if (result !== 32'h0 || wb_rd !== 5'd9) begin errors++; $display("[TB] FAIL add_wrap: got result=%h rd=%0d expected result=0 rd=9", result, wb_rd); end
    tick();
    checks++; if (dbg_rdata !== 32'h0) begin errors++; $display("[TB] FAIL add_wrap_r9: got %h expected %h", dbg_rdata, 32'h0); end
    for (int e = 8; e <= 32; e++) tick();
    checks++; if (pc !== 5'd0) begin errors++; $display("[TB] FAIL pc_wrap: got %h expected %h", pc, 5'd0); end
    tick();
    checks++; if (inst !== prog[0] || pc !== 5'd1) begin errors++; $display("[TB] FAIL refetch: got inst=%h pc=%0d expected inst=%h pc=1", inst, pc, prog[0]); end
    tick();
    checks++; if (result !== 32'd8 || wb_rd !== 5'd3) begin errors++; $display("[TB] FAIL reexec: got result=%h rd=%0d expected result=8 rd=3", result, wb_rd); end
  endtask

  task automatic test_collision();
    for (int i = 0; i < 32; i++) begin prog[i] = 32'h0; regs[i] = 32'h0; end
    prog[0] = mkInst(2'd0, 5'd1, 5'd2, 5'd3);
    regs[1] = 32'd10; regs[2] = 32'd20; regs[3] = 32'h777;
    loadDuringReset();
    tick();
    tick();
    rf_we = 1'b1; rf_waddr = 5'd3; rf_wdata = 32'h1234;
    dbg_raddr = 5'd3;
    tick();
    checks++; if (dbg_rdata !== 32'd30) begin errors++; $display("[TB] FAIL collision_wb_wins: got %h expected %h", dbg_rdata, 32'd30); end
    rf_waddr = 5'd5; rf_wdata = 32'h55;
    dbg_raddr = 5'd5;
    tick();
    rf_we = 1'b0;
    checks++; if (dbg_rdata !== 32'h55) begin errors++; $display("[TB] FAIL host_write_other: got %h expected %h", dbg_rdata, 32'h55); end
    imem_we = 1'b1; imem_waddr = 5'd4; imem_wdata = mkInst(2'd0, 5'd1, 5'd1, 5'd6);
    tick();
    imem_we = 1'b0;
    checks++; if (inst !== 32'h0) begin errors++; $display("[TB] FAIL imem_old_word: got %h expected %h", inst, 32'h0); end
    for (int e = 0; e < 32; e++) tick();
    checks++; if (inst !== mkInst(2'd0, 5'd1, 5'd1, 5'd6)) begin errors++; $display("[TB] FAIL imem_new_word: got %h expected %h", inst, mkInst(2'd0, 5'd1, 5'd1, 5'd6)); end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 32; i++) begin prog[i] = 32'h0; regs[i] = 32'h0; end
    prog[0] = mkInst(2'd0, 5'd1, 5'd2, 5'd3);
    regs[1] = 32'd10; regs[2] = 32'd20; regs[3] = 32'h777;
    loadDuringReset();
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (pc !== 5'd0 || inst !== 32'h0) begin errors++; $display("[TB] FAIL midreset_fetch: got pc=%0d inst=%h expected pc=0 inst=0", pc, inst); end
    checks++; if (result !== 32'h0 || wb_valid !== 1'b0 || wb_rd !== 5'd0) begin errors++; $display("[TB] FAIL midreset_wb: got result=%h valid=%b rd=%0d expected 0/0/0", result, wb_valid, wb_rd); end
    dbg_raddr = 5'd3;
    tick();
    tick();
    checks++; if (dbg_rdata !== 32'h777) begin errors++; $display("[TB] FAIL midreset_no_write: got %h expected %h", dbg_rdata, 32'h777); end
    rst_n = 1'b1;
    tick();
    checks++; if (pc !== 5'd1 || inst !== prog[0]) begin errors++; $display("[TB] FAIL restart: got pc=%0d inst=%h expected pc=1 inst=%h", pc, inst, prog[0]); end
    tick();
    tick();
    checks++; if (dbg_rdata !== 32'd30) begin errors++; $display("[TB] FAIL restart_commit: got %h expected %h", dbg_rdata, 32'd30); end
  endtask

  // Reference: instructions execute in program order on an architectural register copy at
  // fetch time; the visible register file receives each result two edges later.
  task automatic test_random();
    logic [31:0] mImem [32];
    logic [31:0] crf [32];
    logic [31:0] arf [32];
    logic [4:0]  mPc;
    logic        exValid, wbValid;
    logic [31:0] exInst, exResult, wbResult, word;
    logic [4:0]  exRd, wbRd;
    for (int i = 0; i < 32; i++) begin
      prog[i] = randInst();
      case ($urandom_range(0, 3))
        0: regs[i] = 32'hFFFFFFFF;
        1: regs[i] = 32'($urandom_range(0, 15));
        default: regs[i] = $urandom;
      endcase
      mImem[i] = prog[i]; crf[i] = regs[i]; arf[i] = regs[i];
    end
    loadDuringReset();
    mPc = 5'd0; exValid = 1'b0; wbValid = 1'b0;
    exInst = 32'h0; exResult = 32'h0; wbResult = 32'h0; exRd = 5'd0; wbRd = 5'd0;
    for (int cyc = 0; cyc < 120; cyc++) begin
      if (cyc == 60) begin
        #2;
        rst_n = 1'b0;
        #1;
        mPc = 5'd0; exValid = 1'b0; wbValid = 1'b0;
        exInst = 32'h0; wbResult = 32'h0; wbRd = 5'd0;
        for (int i = 0; i < 32; i++) arf[i] = crf[i];
        checks++; if (pc !== 5'd0 || inst !== 32'h0 || result !== 32'h0 || wb_valid !== 1'b0) begin
          errors++; $display("[TB] FAIL rand_async_reset: got pc=%0d inst=%h result=%h valid=%b expected all zero", pc, inst, result, wb_valid);
        end
      end
      if (cyc == 63) rst_n = 1'b1;
      imem_we = ($urandom_range(0, 3) == 0);
      imem_waddr = ($urandom_range(0, 1) == 1) ? pc : 5'($urandom_range(0, 31));
      imem_wdata = randInst();
      dbg_raddr = randReg();
      @(posedge clk);
      if (rst_n) begin
        if (wbValid) crf[wbRd] = wbResult;
        wbValid = exValid;
        if (exValid) begin wbResult = exResult; wbRd = exRd; end
        word = mImem[mPc];
        exInst = word; exValid = 1'b1; exRd = word[19:15];
        exResult = refAlu(word[31:30], arf[word[29:25]], arf[word[24:20]]);
        arf[exRd] = exResult;
        mPc = mPc + 5'd1;
      end
      if (imem_we) mImem[imem_waddr] = imem_wdata;
      #1;
      checks++; if (pc !== mPc) begin errors++; $display("[TB] FAIL rand_pc cyc%0d: got %h expected %h", cyc, pc, mPc); end
      checks++; if (inst !== exInst) begin errors++; $display("[TB] FAIL rand_inst cyc%0d: got %h expected %h", cyc, inst, exInst); end
      checks++; if (wb_valid !== wbValid) begin errors++; $display("[TB] FAIL rand_wb_valid cyc%0d: got %b expected %b", cyc, wb_valid, wbValid); end
      checks++; if (result !== wbResult || wb_rd !== wbRd) begin errors++; $display("[TB] FAIL rand_result cyc%0d: got %h/rd%0d expected %h/rd%0d", cyc, result, wb_rd, wbResult, wbRd); end
      checks++; if (dbg_rdata !== crf[dbg_raddr]) begin errors++; $display("[TB] FAIL rand_dbg cyc%0d r%0d: got %h expected %h", cyc, dbg_raddr, dbg_rdata, crf[dbg_raddr]); end
    end
    imem_we = 1'b0;
  endtask

  initial begin
    test_reset();
    test_alu_forwarding();
    test_collision();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
